// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multiport register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: zero-register override, write-to-read forwarding, array data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_c
);

  logic is_zero_c;
  logic is_fwd_c;

  // Zero register wins over forwarding, forwarding wins over stored data.
  always_comb begin
    is_zero_c = OFF;
    is_fwd_c  = OFF;
    data_c    = mem_data;
    if (ZERO_REG != 0) begin
      is_zero_c = (addr == '0);
    end
    if (BYPASS != 0) begin
      is_fwd_c = write_enabled && (addr == write_addr);
    end
    if (is_zero_c) begin
      data_c = '0;
    end else if (is_fwd_c) begin
      data_c = write_data;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with request/finish handshake and a zeroing sweep.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             read_enabled,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  input  logic                             write_enabled,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             clear,
  output logic                             busy,
  output logic                             finish,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                          state;
  state_t                          next_state;
  logic [ADDR_WIDTH-1:0]           counter;
  logic [ADDR_WIDTH-1:0]           next_counter;
  logic                            next_busy;
  logic                            next_finish;
  logic                            load_read_c;
  logic                            mem_we_c;
  logic [ADDR_WIDTH-1:0]           mem_waddr_c;
  logic [DATA_WIDTH-1:0]           mem_wdata_c;
  logic [READ_PORTS*DATA_WIDTH-1:0] port_data_c;

  // Per-port address decode and forwarding.
  for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_read_port (
      .addr          (read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_data      (mem[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .write_enabled (write_enabled),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .data_c        (port_data_c[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Next-state, sweep counter, array write and handshake decode.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    next_busy    = busy;
    next_finish  = OFF;
    load_read_c  = OFF;
    mem_we_c     = OFF;
    mem_waddr_c  = write_addr;
    mem_wdata_c  = write_data;
    case (state)
      IDLE: begin
        if (clear) begin
          next_state   = CLEAR;
          next_counter = '0;
          next_busy    = ON;
        end else if (start) begin
          next_finish = ON;
          load_read_c = read_enabled;
          mem_we_c    = write_enabled;
          if ((ZERO_REG != 0) && (write_addr == '0)) begin
            mem_we_c = OFF;
          end
        end
      end
      CLEAR: begin
        mem_we_c    = ON;
        mem_waddr_c = counter;
        mem_wdata_c = '0;
        if (counter == LAST_INDEX) begin
          next_state   = IDLE;
          next_counter = '0;
          next_busy    = OFF;
          next_finish  = ON;
        end else begin
          next_counter = counter + ADDR_WIDTH'(1);
        end
      end
      default: begin
        next_state   = CLEAR;
        next_counter = '0;
        next_busy    = ON;
      end
    endcase
  end

  // State, counter and registered outputs; reset restarts the sweep.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= CLEAR;
      counter   <= '0;
      busy      <= ON;
      finish    <= OFF;
      read_data <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      busy    <= next_busy;
      finish  <= next_finish;
      if (load_read_c) begin
        read_data <= port_data_c;
      end
    end
  end

  // Storage array; only the sweep clears it.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: a forwarding and a non-forwarding instance driven in lockstep.
module tb_regfile_multiport;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        read_enabled = 1'b0;
  logic [9:0]  read_addr = '0;
  logic        write_enabled = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic        clear = 1'b0;
  logic        busy, finish, busy_nb, finish_nb;
  logic [63:0] read_data, read_data_nb;

  regfile_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .read_enabled(read_enabled),
    .read_addr(read_addr), .write_enabled(write_enabled), .write_addr(write_addr),
    .write_data(write_data), .clear(clear), .busy(busy), .finish(finish), .read_data(read_data));

  regfile_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .start(start), .read_enabled(read_enabled),
    .read_addr(read_addr), .write_enabled(write_enabled), .write_addr(write_addr),
    .write_data(write_data), .clear(clear), .busy(busy_nb), .finish(finish_nb), .read_data(read_data_nb));

  always #5 clock = ~clock;

  typedef struct {
    int          exp_cycle;
    logic [63:0] rd_bp;
    logic [63:0] rd_nb;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          check_on = 1'b0;
  int          busy_start = 0;
  int          sweep_end = 0;
  logic [31:0] mref [32];
  logic [31:0] rd_bp [2];
  logic [31:0] rd_nb [2];
  bit          exp_busy;

  always @(posedge clock) cyc++;

  // Monitor: busy every cycle, and each finish pulse against the queue head.
  always @(negedge clock) begin
    if (check_on) begin
      exp_busy = (cyc >= busy_start) && (cyc < sweep_end);
      compared++;
      if (busy !== exp_busy || busy_nb !== exp_busy) begin
        mismatched++;
        $display("FAIL busy @%0d: got %b/%b expected %b", cyc, busy, busy_nb, exp_busy);
      end
      if (q.size() > 0 && q[0].exp_cycle < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_finish @%0d: expected finish at cycle %0d", cyc, q[0].exp_cycle);
        void'(q.pop_front());
      end
      if (finish === 1'b1 || finish_nb === 1'b1) begin
        compared++;
        if (q.size() == 0 || q[0].exp_cycle != cyc) begin
          mismatched++;
          $display("FAIL unexpected_finish @%0d: got %b/%b expected no pulse", cyc, finish, finish_nb);
        end else begin
          mon_e = q.pop_front();
          if (finish !== 1'b1 || finish_nb !== 1'b1 ||
              read_data !== mon_e.rd_bp || read_data_nb !== mon_e.rd_nb) begin
            mismatched++;
            $display("FAIL read_data @%0d: got fin %b/%b bp %h nb %h expected bp %h nb %h",
                     cyc, finish, finish_nb, read_data, read_data_nb, mon_e.rd_bp, mon_e.rd_nb);
          end
        end
      end
    end
  end

  function automatic void zero_model();
    for (int i = 0; i < 32; i++) mref[i] = '0;
  endfunction

  // Apply one cycle of stimulus; the reference model decides what the next edge does.
  task automatic drive(input bit st, input bit clr, input bit re, input int ra0, input int ra1,
                       input bit we, input int wa, input logic [31:0] wd);
    int e;
    int a;
    start = st; clear = clr; read_enabled = re; write_enabled = we;
    read_addr = {5'(ra1), 5'(ra0)};
    write_addr = 5'(wa);
    write_data = wd;
    e = cyc + 1;
    if (e > sweep_end) begin
      if (clr) begin
        busy_start = e;
        sweep_end = e + 32;
        zero_model();
        q.push_back('{sweep_end, {rd_bp[1], rd_bp[0]}, {rd_nb[1], rd_nb[0]}});
      end else if (st) begin
        if (re) begin
          for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? ra0 : ra1;
            if (a == 0) begin
              rd_bp[p] = '0; rd_nb[p] = '0;
            end else if (we && a == wa) begin
              rd_bp[p] = wd; rd_nb[p] = mref[a];
            end else begin
              rd_bp[p] = mref[a]; rd_nb[p] = mref[a];
            end
          end
        end
        if (we && wa != 0) mref[wa] = wd;
        q.push_back('{e, {rd_bp[1], rd_bp[0]}, {rd_nb[1], rd_nb[0]}});
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Hold reset for n edges; pending finishes not yet due are cancelled.
  task automatic do_reset(input int n);
    exp_t keep[$];
    start = 0; clear = 0; read_enabled = 0; write_enabled = 0; reset_n = 0;
    if (!(cyc >= busy_start && cyc < sweep_end)) busy_start = cyc + 1;
    foreach (q[i]) if (q[i].exp_cycle <= cyc) keep.push_back(q[i]);
    q = keep;
    sweep_end = cyc + n + 32;
    rd_bp[0] = '0; rd_bp[1] = '0; rd_nb[0] = '0; rd_nb[1] = '0;
    zero_model();
    q.push_back('{sweep_end, 64'd0, 64'd0});
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1;
    check_on = 1'b1;
  endtask

  task automatic wait_idle();
    while (cyc < sweep_end) drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    int target, wa, ra0, ra1;
    @(posedge clock);
    #1;
    // Reset sweep, then every register reads zero.
    do_reset(2);
    wait_idle();
    for (int k = 0; k < 16; k++) drive(1, 0, 1, 2 * k, 2 * k + 1, 0, 0, 32'd0);
    // Forwarded vs. pre-write value on the same request.
    drive(1, 0, 1, 5, 5, 1, 5, 32'hDEADBEEF);
    drive(1, 0, 1, 5, 0, 0, 0, 32'd0);
    // Zero register ignores writes, forwarded or stored.
    drive(1, 0, 1, 0, 0, 1, 0, 32'hFFFFFFFF);
    drive(1, 0, 1, 0, 0, 0, 0, 32'd0);
    // read_data holds when read is disabled.
    drive(1, 0, 0, 5, 5, 1, 7, 32'h77);
    // Clear beats a simultaneous start.
    drive(1, 1, 1, 3, 3, 1, 3, 32'h12);
    drive(1, 0, 1, 3, 3, 1, 4, 32'h44);
    wait_idle();
    drive(1, 0, 1, 3, 5, 0, 0, 32'd0);
    // Back-to-back requests.
    drive(1, 0, 0, 0, 0, 1, 1, 32'd1);
    drive(1, 0, 0, 0, 0, 1, 2, 32'd2);
    drive(1, 0, 0, 0, 0, 1, 3, 32'd3);
    drive(1, 0, 1, 1, 3, 0, 0, 32'd0);
    // Reset in the middle of a sweep restarts it.
    do_reset(2);
    target = cyc + 10;
    while (cyc < target) drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
    do_reset(1);
    wait_idle();
    drive(1, 0, 1, 1, 2, 0, 0, 32'd0);
    // Randomized traffic with occasional clears.
    for (int i = 0; i < 500; i++) begin
      wa  = $urandom_range(0, 31);
      ra0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            ra0, ra1, 1'($urandom_range(0, 1)), wa, $urandom);
    end
    wait_idle();
    for (int k = 0; k < 16; k++) drive(1, 0, 1, 2 * k, 2 * k + 1, 0, 0, 32'd0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
